inst_decoder: RTL and testbench
===============================

// Module: inst_decoder
// PURPOSE
//  Registered RV32I instruction-field decoder, first stage after fetch.
//  Slices the 32-bit instruction into opcode/rd/func3/rs1/rs2/func7.
//  Also produces format class, sign-extended immediate, shamt, register-use flags and an illegal flag.
//  All outputs are registered: one pipeline stage between fetch and the register file and control.
// PARAMETERS
//  WIDTH  32  instruction width; only 32 is supported
// PORTS
//  clk        in   1      rising-edge clock (single clock domain)
//  rst_n      in   1      asynchronous, active-low reset
//  inst       in   WIDTH  raw instruction word
//  in_valid   in   1      inst is valid this cycle
//  out_valid  out  1      decoded outputs valid
//  opcode     out  7      inst[6:0]
//  rd         out  5      inst[11:7]
//  func3      out  3      inst[14:12]
//  rs1        out  5      inst[19:15]
//  rs2        out  5      inst[24:20]
//  func7      out  7      inst[31:25]
//  shamt      out  5      inst[24:20], shift amount
//  fmt        out  3      R=0 I=1 S=2 B=3 U=4 J=5 invalid=7
//  imm        out  32     sign-extended immediate per fmt
//  use_rs1    out  1      instruction reads rs1
//  use_rs2    out  1      instruction reads rs2
//  wr_rd      out  1      writes rd (fmt not S/B, rd!=0)
//  illegal    out  1      unsupported encoding
// BEHAVIOUR
//  - Reset (rst_n=0, async): every output is 0; out_valid is 0. Clock edges are ignored while in reset.
//  - Latency 1: on a clk edge with in_valid=1, all outputs are computed from inst and out_valid<=1.
//  - in_valid=0: out_valid<=0; all other outputs hold their last values.
//  - Field slices are unconditional, whatever the opcode.
//  - Opcode map -> fmt:
//    0110111 LUI, 0010111 AUIPC -> U
//    1101111 JAL -> J
//    1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 FENCE, 1110011 SYSTEM -> I
//    1100011 BRANCH -> B
//    0100011 STORE -> S
//    0110011 OP -> R
//    any other value -> fmt=7, illegal=1
//  - imm (i = inst):
//    I: {{20{i[31]}}, i[31:20]}
//    S: {{20{i[31]}}, i[31:25], i[11:7]}
//    B: {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}
//    U: {i[31:12], 12'b0}
//    J: {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}
//    R and invalid: 0
//    OP-IMM shifts keep the raw I immediate (SRAI imm=0x400|shamt).
//  - use_rs1=1 for R/I/S/B formats; use_rs2=1 for R/S/B; both are 0 for U/J/invalid.
//  - illegal is also set when:
//    OP-IMM func3=001 and func7!=0
//    OP-IMM func3=101 and func7 not 0x00/0x20
//    OP with func7 not 0x00/0x20
//    inst[1:0]!=2'b11
//  - illegal=1 forces wr_rd=0, use_rs1=0 and use_rs2=0. Field outputs still reflect inst.
//  - Reset asserted mid-stream clears out_valid and all fields immediately.
// TESTING
//  - Reset: rst_n=0 -> all outputs 0. Release, in_valid=0 -> out_valid stays 0.
//  - 32'h41635293 (SRAI x5,x6,22), one edge later:
//    opcode=0x13 rd=5 func3=5 rs1=6 rs2=22 func7=0x20 shamt=22
//    fmt=1 imm=0x416 wr_rd=1 illegal=0
//  - Back-to-back cycles with in_valid=1; each result follows its input by one cycle:
//    32'h4190d393 -> rd=7 rs1=1 rs2=25
//    32'h41f15293 -> rd=5 rs1=2 rs2=31
//    32'h4034d413 -> rd=8 rs1=9 rs2=3
//    each with func3=5 func7=0x20
//  - 32'hFE000EE3 (BEQ x0,x0,-4) -> fmt=3 imm=0xFFFFFFFC use_rs2=1 wr_rd=0
//  - 32'h0000007F -> fmt=7 illegal=1 imm=0 wr_rd=0
//    Then in_valid=0 -> out_valid=0 and fields hold their values.

Source files
------------

// File: rtl/inst_decoder.sv
// Registered RV32I instruction-field decoder: slices the instruction word,
// classifies its format, builds the sign-extended immediate and the
// register-use / illegal flags, all presented one clock after the input.
module inst_decoder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inst,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       func3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       func7,
  output logic [4:0]       shamt,
  output logic [2:0]       fmt,
  output logic [31:0]      imm,
  output logic             use_rs1,
  output logic             use_rs2,
  output logic             wr_rd,
  output logic             illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_INV = 3'd7;

  logic [31:0] i;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [2:0]  fmt_d;
  logic [31:0] imm_d;
  logic        ill_d, rs1_d, rs2_d, wr_d;

  logic        out_valid_q;
  logic [31:0] inst_q;
  logic [2:0]  fmt_q;
  logic [31:0] imm_q;
  logic        ill_q, rs1_q, rs2_q, wr_q;

  assign i  = inst[31:0];
  assign f7 = i[31:25];
  assign f3 = i[14:12];

  // Format class, immediate and control flags from the raw word.
  always_comb begin
    fmt_d = FMT_INV;
    ill_d = 1'b0;
    imm_d = '0;
    case (i[6:0])
      OP_LUI, OP_AUIPC:                             fmt_d = FMT_U;
      OP_JAL:                                       fmt_d = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: fmt_d = FMT_I;
      OP_BRANCH:                                    fmt_d = FMT_B;
      OP_STORE:                                     fmt_d = FMT_S;
      OP_OP:                                        fmt_d = FMT_R;
      default:                                      fmt_d = FMT_INV;
    endcase
    // Shift encodings only allow the SRL/SRA distinguishing bit in func7.
    if (fmt_d == FMT_INV || i[1:0] != 2'b11) ill_d = 1'b1;
    if (i[6:0] == OP_IMM && f3 == 3'b001 && f7 != 7'h00) ill_d = 1'b1;
    if (i[6:0] == OP_IMM && f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) ill_d = 1'b1;
    if (i[6:0] == OP_OP && f7 != 7'h00 && f7 != 7'h20) ill_d = 1'b1;
    case (fmt_d)
      FMT_I:   imm_d = {{20{i[31]}}, i[31:20]};
      FMT_S:   imm_d = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   imm_d = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   imm_d = {i[31:12], 12'b0};
      FMT_J:   imm_d = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm_d = '0;
    endcase
    rs1_d = !ill_d && (fmt_d == FMT_R || fmt_d == FMT_I || fmt_d == FMT_S || fmt_d == FMT_B);
    rs2_d = !ill_d && (fmt_d == FMT_R || fmt_d == FMT_S || fmt_d == FMT_B);
    wr_d  = !ill_d && fmt_d != FMT_S && fmt_d != FMT_B && i[11:7] != 5'd0;
  end

  // Output stage: capture on in_valid, otherwise hold everything but valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      inst_q      <= '0;
      fmt_q       <= '0;
      imm_q       <= '0;
      ill_q       <= 1'b0;
      rs1_q       <= 1'b0;
      rs2_q       <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        inst_q <= i;
        fmt_q  <= fmt_d;
        imm_q  <= imm_d;
        ill_q  <= ill_d;
        rs1_q  <= rs1_d;
        rs2_q  <= rs2_d;
        wr_q   <= wr_d;
      end
    end
  end

  // Field slices come straight from the captured word.
  assign out_valid = out_valid_q;
  assign opcode    = inst_q[6:0];
  assign rd        = inst_q[11:7];
  assign func3     = inst_q[14:12];
  assign rs1       = inst_q[19:15];
  assign rs2       = inst_q[24:20];
  assign func7     = inst_q[31:25];
  assign shamt     = inst_q[24:20];
  assign fmt       = fmt_q;
  assign imm       = imm_q;
  assign use_rs1   = rs1_q;
  assign use_rs2   = rs2_q;
  assign wr_rd     = wr_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_inst_decoder.sv
// Scoreboard bench for inst_decoder: a behavioural decode model pushes the
// expected outputs when stimulus is driven; a monitor pops and compares after
// each rising edge. Spec vectors are also checked against literal constants.
module tb_inst_decoder;

  typedef struct packed {
    logic        vld;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [4:0]  sh;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        u1;
    logic        u2;
    logic        wr;
    logic        ill;
  } dec_t;

  logic        clk, rst_n, in_valid;
  logic [31:0] inst;
  logic        out_valid, use_rs1, use_rs2, wr_rd, illegal;
  logic [6:0]  opcode, func7;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  func3, fmt;
  logic [31:0] imm;

  int   n_chk, n_err;
  dec_t exp_q[$];
  dec_t last;
  dec_t obs;

  inst_decoder #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .in_valid(in_valid),
    .out_valid(out_valid), .opcode(opcode), .rd(rd), .func3(func3),
    .rs1(rs1), .rs2(rs2), .func7(func7), .shamt(shamt), .fmt(fmt),
    .imm(imm), .use_rs1(use_rs1), .use_rs2(use_rs2), .wr_rd(wr_rd),
    .illegal(illegal)
  );

  assign obs = {out_valid, opcode, rd, func3, rs1, rs2, func7, shamt, fmt,
                imm, use_rs1, use_rs2, wr_rd, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    if (o !== e) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, o, e, $time);
    end
  endtask

  task automatic chk_dec(input string tag, input dec_t o, input dec_t e);
    chk({tag, ".vld"}, 32'(o.vld), 32'(e.vld));
    chk({tag, ".opc"}, 32'(o.opc), 32'(e.opc));
    chk({tag, ".rd"},  32'(o.rd),  32'(e.rd));
    chk({tag, ".f3"},  32'(o.f3),  32'(e.f3));
    chk({tag, ".rs1"}, 32'(o.rs1), 32'(e.rs1));
    chk({tag, ".rs2"}, 32'(o.rs2), 32'(e.rs2));
    chk({tag, ".f7"},  32'(o.f7),  32'(e.f7));
    chk({tag, ".sh"},  32'(o.sh),  32'(e.sh));
    chk({tag, ".fmt"}, 32'(o.fmt), 32'(e.fmt));
    chk({tag, ".imm"}, o.imm, e.imm);
    chk({tag, ".u1"},  32'(o.u1),  32'(e.u1));
    chk({tag, ".u2"},  32'(o.u2),  32'(e.u2));
    chk({tag, ".wr"},  32'(o.wr),  32'(e.wr));
    chk({tag, ".ill"}, 32'(o.ill), 32'(e.ill));
  endtask

  // Reference decode written from the ISA tables, using signed arithmetic.
  function automatic dec_t model(input logic [31:0] w);
    dec_t d;
    logic signed [11:0] si;
    logic signed [12:0] sb;
    logic signed [20:0] sj;
    logic legal_opc, r, is_i, s, b;
    d = '0;
    d.vld = 1'b1;
    d.opc = w[6:0];   d.rd  = w[11:7];  d.f3 = w[14:12];
    d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f7 = w[31:25]; d.sh = w[24:20];
    si = w[31:20];
    sb = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    sj = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    legal_opc = 1'b1;
    unique case (w[6:0])
      7'h37, 7'h17:                      begin d.fmt = 3'd4; d.imm = w & 32'hFFFF_F000; end
      7'h6F:                             begin d.fmt = 3'd5; d.imm = 32'(sj); end
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin d.fmt = 3'd1; d.imm = 32'(si); end
      7'h63:                             begin d.fmt = 3'd3; d.imm = 32'(sb); end
      7'h23: begin d.fmt = 3'd2; d.imm = (32'(si) & ~32'h1F) | 32'(w[11:7]); end
      7'h33:                             begin d.fmt = 3'd0; d.imm = 32'h0; end
      default: begin d.fmt = 3'd7; d.imm = 32'h0; legal_opc = 1'b0; end
    endcase
    d.ill = !legal_opc;
    if (w[6:0] == 7'h13 && w[14:12] == 3'd1 && w[31:25] != 7'd0) d.ill = 1'b1;
    if (w[6:0] == 7'h13 && w[14:12] == 3'd5 && !(w[31:25] inside {7'h00, 7'h20})) d.ill = 1'b1;
    if (w[6:0] == 7'h33 && !(w[31:25] inside {7'h00, 7'h20})) d.ill = 1'b1;
    r = d.fmt == 3'd0; is_i = d.fmt == 3'd1; s = d.fmt == 3'd2; b = d.fmt == 3'd3;
    if (!d.ill) begin
      d.u1 = r | is_i | s | b;
      d.u2 = r | s | b;
      d.wr = !(s | b) && w[11:7] != 5'd0;
    end
    return d;
  endfunction

  // Drive one cycle's stimulus at the falling edge and log the expectation.
  task automatic drive(input logic v, input logic [31:0] w);
    @(negedge clk);
    in_valid = v;
    inst     = w;
    if (v) last = model(w);
    else    last.vld = 1'b0;
    exp_q.push_back(last);
  endtask

  // Monitor: one expectation per rising edge while out of reset.
  always begin
    @(posedge clk);
    #1;
    if (rst_n && exp_q.size() > 0) chk_dec("sb", obs, exp_q.pop_front());
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  logic [6:0] opcs [11];

  initial begin
    n_chk = 0; n_err = 0;
    last = '0;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h63, 7'h23, 7'h33};
    rst_n = 1'b0; in_valid = 1'b0; inst = 32'h0;
    #12;
    chk_dec("reset", obs, '0);
    @(negedge clk); rst_n = 1'b1;
    drive(1'b0, 32'h0);
    drain();
    chk("idle_vld", 32'(out_valid), 32'd0);

    // SRAI x5,x6,22
    drive(1'b1, 32'h41635293);
    drain();
    chk("srai_opc", 32'(opcode), 32'h13);
    chk("srai_rd", 32'(rd), 32'd5);
    chk("srai_f3", 32'(func3), 32'd5);
    chk("srai_rs1", 32'(rs1), 32'd6);
    chk("srai_rs2", 32'(rs2), 32'd22);
    chk("srai_f7", 32'(func7), 32'h20);
    chk("srai_sh", 32'(shamt), 32'd22);
    chk("srai_fmt", 32'(fmt), 32'd1);
    chk("srai_imm", imm, 32'h416);
    chk("srai_wr", 32'(wr_rd), 32'd1);
    chk("srai_ill", 32'(illegal), 32'd0);

    // Back-to-back, scoreboard tracks each one-cycle result
    drive(1'b1, 32'h4190d393);
    drive(1'b1, 32'h41f15293);
    drive(1'b1, 32'h4034d413);
    drain();
    chk("b2b_rd", 32'(rd), 32'd8);
    chk("b2b_rs1", 32'(rs1), 32'd9);
    chk("b2b_rs2", 32'(rs2), 32'd3);

    // BEQ x0,x0,-4
    drive(1'b1, 32'hFE000EE3);
    drain();
    chk("beq_fmt", 32'(fmt), 32'd3);
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_u2", 32'(use_rs2), 32'd1);
    chk("beq_wr", 32'(wr_rd), 32'd0);

    // Unknown opcode, then hold
    drive(1'b1, 32'h0000007F);
    drain();
    chk("inv_fmt", 32'(fmt), 32'd7);
    chk("inv_ill", 32'(illegal), 32'd1);
    chk("inv_imm", imm, 32'h0);
    chk("inv_wr", 32'(wr_rd), 32'd0);
    drive(1'b0, 32'h12345678);
    drive(1'b0, 32'h00000033);
    drain();
    chk("hold_vld", 32'(out_valid), 32'd0);
    chk("hold_fmt", 32'(fmt), 32'd7);
    chk("hold_ill", 32'(illegal), 32'd1);

    // Illegal shift / OP encodings and a bad low-bit pattern
    drive(1'b1, 32'h02001093);   // SLLI with func7!=0
    drive(1'b1, 32'h40005093);   // SRLI func7=0x20: legal SRAI
    drive(1'b1, 32'h60005093);   // bad func7 on shift right
    drive(1'b1, 32'h02000033);   // OP func7=0x01 (M ext)
    drive(1'b1, 32'h00000012);   // inst[1:0]!=11
    drive(1'b1, 32'h800000B7);   // LUI
    drive(1'b1, 32'h8000006F);   // JAL with rd=0
    drive(1'b1, 32'hFE112E23);   // SW negative offset
    drain();

    // Random traffic with gaps
    for (int k = 0; k < 300; k++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
      case ($urandom_range(0, 2))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
      drive(1'($urandom_range(0, 3) != 0), w);
    end
    drain();

    // Async reset mid-stream, clock ignored while held
    drive(1'b1, 32'h00A00513);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_dec("midrst", obs, '0);
    last = '0;
    in_valid = 1'b1; inst = 32'h41635293;
    repeat (2) @(posedge clk);
    #1;
    chk_dec("inrst", obs, '0);
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    drive(1'b1, 32'h00C58633);
    drive(1'b0, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
